// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-rate divider, H/V counters and
// registered sync/blank decodes aligned with the counter values they describe.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
    $error("vga_sync_gen: totals must fit 10-bit counters and CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_p0;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             frame_wrap;

  // Next-state of divider and counters; the output decodes below are taken
  // from these so they line up with the counter values of the same cycle.
  always_comb begin
    div_nxt    = (div_p0 == DIV_LAST) ? '0 : div_p0 + DIV_W'(1);
    h_nxt      = HCount;
    v_nxt      = VCount;
    frame_wrap = 1'b0;
    if (pixel_tick) begin
      if (HCount == H_LAST) begin
        h_nxt = '0;
        if (VCount == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = VCount + 10'd1;
        end
      end else begin
        h_nxt = HCount + 10'd1;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      div_p0     <= '0;
      HCount     <= '0;
      VCount     <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      pixel_tick <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_p0     <= div_nxt;
      HCount     <= h_nxt;
      VCount     <= v_nxt;
      hsync      <= !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
      vsync      <= !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
      video_on   <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      pixel_tick <= (div_nxt == DIV_LAST);
      frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default build, CLK_DIV=1 build and a reduced-timing
// build run side by side against a pixel-count reference model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       ft;
  } st_t;

  localparam st_t RST = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b0, pt: 1'b0, ft: 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  longint t = 0;  // edges since reset was last sampled high

  always @(posedge clk) t <= reset ? 64'd0 : t + 64'd1;

  logic [9:0] d_h, d_v, d1_h, d1_v, s_h, s_v;
  logic d_hs, d_vs, d_vo, d_pt, d_ft;
  logic d1_hs, d1_vs, d1_vo, d1_pt, d1_ft;
  logic s_hs, s_vs, s_vo, s_pt, s_ft;

  vga_sync_gen u_dut (
    .clk(clk), .reset(reset), .HCount(d_h), .VCount(d_v), .hsync(d_hs), .vsync(d_vs),
    .video_on(d_vo), .pixel_tick(d_pt), .frame_tick(d_ft)
  );

  vga_sync_gen #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .HCount(d1_h), .VCount(d1_v), .hsync(d1_hs), .vsync(d1_vs),
    .video_on(d1_vo), .pixel_tick(d1_pt), .frame_tick(d1_ft)
  );

  vga_sync_gen #(.CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_small (
    .clk(clk), .reset(reset), .HCount(s_h), .VCount(s_v), .hsync(s_hs), .vsync(s_vs),
    .video_on(s_vo), .pixel_tick(s_pt), .frame_tick(s_ft)
  );

  st_t o_dut, o_div1, o_small;
  logic [3*$bits(st_t)-1:0] o_all;
  assign o_dut   = {d_h, d_v, d_hs, d_vs, d_vo, d_pt, d_ft};
  assign o_div1  = {d1_h, d1_v, d1_hs, d1_vs, d1_vo, d1_pt, d1_ft};
  assign o_small = {s_h, s_v, s_hs, s_vs, s_vo, s_pt, s_ft};
  assign o_all   = {o_dut, o_div1, o_small};

  // Pixel ticks consumed after t edges: one per CLK_DIV clocks, but the tick
  // strobe itself is first visible one cycle after reset release.
  function automatic longint pix(longint d, longint tt);
    if (tt <= 0) return 0;
    return (d == 1) ? tt - 1 : tt / d;
  endfunction

  function automatic st_t model(longint d, longint hd, longint hf, longint hs, longint hb,
                                longint vd, longint vf, longint vs, longint vb, longint tt);
    st_t e;
    longint p, ht, vt, hh, vv;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    p  = pix(d, tt);
    hh = p % ht;
    vv = (p / ht) % vt;
    e.h  = 10'(hh);
    e.v  = 10'(vv);
    e.hs = !(hh >= hd + hf && hh < hd + hf + hs);
    e.vs = !(vv >= vd + vf && vv < vd + vf + vs);
    e.vo = (tt > 0) && (hh < hd) && (vv < vd);
    e.pt = (tt > 0) && ((tt % d) == d - 1);
    e.ft = (tt > 0) && (p != pix(d, tt - 1)) && ((p % (ht * vt)) == 0);
    return e;
  endfunction

  function automatic logic [3*$bits(st_t)-1:0] exp_all(longint tt);
    return {model(2, 640, 16, 96, 48, 480, 10, 2, 33, tt),
            model(1, 640, 16, 96, 48, 480, 10, 2, 33, tt),
            model(3, 8, 2, 3, 2, 6, 1, 2, 1, tt)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_all !== {3{RST}}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", o_all, {3{RST}});
    end
  endtask

  task automatic test_startup();
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (o_all !== exp_all(t)) begin
        failures++;
        $display("FAIL startup_model t=%0d got=%h exp=%h", t, o_all, exp_all(t));
      end
      if (i == 1) begin
        checks++;
        if ({d_h, d_pt, d_vo, d1_pt} !== {10'd0, 1'b1, 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL startup_edge1 got h=%0d pt=%b vo=%b pt1=%b exp h=0 pt=1 vo=1 pt1=1",
                   d_h, d_pt, d_vo, d1_pt);
        end
      end
      if (i == 2) begin
        checks++;
        if ({d_h, d_pt} !== {10'd1, 1'b0}) begin
          failures++;
          $display("FAIL startup_edge2 got h=%0d pt=%b exp h=1 pt=0", d_h, d_pt);
        end
      end
    end
  endtask

  task automatic test_hsync_line();
    int low = 0;
    int minh = 1023;
    int maxh = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      checks++;
      if (o_all !== exp_all(t)) begin
        failures++;
        $display("FAIL hsync_line_model t=%0d got=%h exp=%h", t, o_all, exp_all(t));
      end
      if (d_pt && !d_hs) begin
        low++;
        if (int'(d_h) < minh) minh = int'(d_h);
        if (int'(d_h) > maxh) maxh = int'(d_h);
      end
    end
    checks++;
    if (low != 96 || minh != 656 || maxh != 751) begin
      failures++;
      $display("FAIL hsync_window got ticks=%0d first=%0d last=%0d exp 96/656/751", low, minh, maxh);
    end
  endtask

  task automatic test_line_wrap();
    logic [9:0] ph = d_h;
    logic [9:0] pv = d_v;
    bit seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      checks++;
      if (o_all !== exp_all(t)) begin
        failures++;
        $display("FAIL line_wrap_model t=%0d got=%h exp=%h", t, o_all, exp_all(t));
      end
      if (ph == 10'd799 && pv == 10'd10 && d_h != 10'd799) begin
        seen = 1;
        checks++;
        if ({d_h, d_v} !== {10'd0, 10'd11}) begin
          failures++;
          $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=11", d_h, d_v);
        end
      end
      ph = d_h;
      pv = d_v;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL line_wrap_timeout got no 799/10 wrap within bound, exp wrap to 0/11");
    end
  endtask

  task automatic test_small_frame();
    longint last_ft = -1;
    int nft = 0;
    int vmin = 1023;
    int vmax = 0;
    for (int i = 0; i < 5 * 450; i++) begin
      @(negedge clk);
      checks++;
      if (o_all !== exp_all(t)) begin
        failures++;
        $display("FAIL frame_model t=%0d got=%h exp=%h", t, o_all, exp_all(t));
      end
      if (s_ft) begin
        checks++;
        if ({s_h, s_v} !== 20'd0 || (last_ft >= 0 && t - last_ft != 450)) begin
          failures++;
          $display("FAIL frame_tick got h=%0d v=%0d period=%0d exp 0/0 period 450",
                   s_h, s_v, t - last_ft);
        end
        last_ft = t;
        nft++;
      end
      if (s_h == 10'd7 && s_v == 10'd5) begin
        checks++;
        if (s_vo !== 1'b1) begin
          failures++;
          $display("FAIL video_on_corner got=%b exp=1", s_vo);
        end
      end
      if (s_h == 10'd8 || s_v == 10'd6) begin
        checks++;
        if (s_vo !== 1'b0) begin
          failures++;
          $display("FAIL video_on_edge h=%0d v=%0d got=%b exp=0", s_h, s_v, s_vo);
        end
      end
      if (!s_vs) begin
        if (int'(s_v) < vmin) vmin = int'(s_v);
        if (int'(s_v) > vmax) vmax = int'(s_v);
      end
    end
    checks++;
    if (nft < 4 || vmin != 7 || vmax != 8) begin
      failures++;
      $display("FAIL frame_summary got ticks=%0d vs_first=%0d vs_last=%0d exp >=4/7/8", nft, vmin, vmax);
    end
  endtask

  task automatic test_clk_div1();
    logic [9:0] ph = d1_h;
    longint last0 = -1;
    int lines = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      checks++;
      if (o_all !== exp_all(t) || d1_pt !== 1'b1) begin
        failures++;
        $display("FAIL div1_model t=%0d got=%h exp=%h pt1=%b", t, o_all, exp_all(t), d1_pt);
      end
      if (ph == 10'd799 && d1_h == 10'd0) begin
        if (last0 >= 0) begin
          checks++;
          if (t - last0 != 800) begin
            failures++;
            $display("FAIL div1_line_period got=%0d exp=800", t - last0);
          end
        end
        last0 = t;
        lines++;
      end
      ph = d1_h;
    end
    checks++;
    if (lines < 3) begin
      failures++;
      $display("FAIL div1_lines got=%0d exp>=3", lines);
    end
  endtask

  task automatic test_mid_reset();
    for (int r = 0; r < 4; r++) begin
      int run = $urandom_range(3000, 50);
      int hold = $urandom_range(3, 1);
      for (int i = 0; i < run; i++) begin
        @(negedge clk);
        checks++;
        if (o_all !== exp_all(t)) begin
          failures++;
          $display("FAIL mid_run_model t=%0d got=%h exp=%h", t, o_all, exp_all(t));
        end
      end
      reset = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checks++;
        if (o_all !== {3{RST}}) begin
          failures++;
          $display("FAIL mid_reset got=%h exp=%h", o_all, {3{RST}});
        end
      end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        checks++;
        if (o_all !== exp_all(t)) begin
          failures++;
          $display("FAIL post_reset_model t=%0d got=%h exp=%h", t, o_all, exp_all(t));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_hsync_line();
    test_line_wrap();
    test_small_frame();
    test_clk_div1();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
